// File: rtl/acc_trace_pkg.sv
// Shared definitions for the acc/mr trace transmitter.
//   state_t       : UART framing FSM states
//   SYNC_BYTE     : marker byte sent ahead of each record when TRACE_SYNC_EN is defined
//   REC_W         : record width, {mr, acc}
//   BYTES_PER_REC : bytes per serialised record (5 with TRACE_SYNC_EN, else 4)
//   rec_byte()    : selects the idx-th byte of a record in transmit order
// Build option: TRACE_SYNC_EN.
package acc_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         REC_W     = 32;

`ifdef TRACE_SYNC_EN
  localparam int BYTES_PER_REC = 5;
`else
  localparam int BYTES_PER_REC = 4;
`endif

  // The sync byte sits above the record; with 4 bytes per record the
  // indexing simply never reaches it. Order: [sync,] mr hi, mr lo, acc hi, acc lo.
  function automatic logic [7:0] rec_byte(input logic [REC_W-1:0] rec,
                                          input logic [2:0]       idx);
    logic [REC_W+7:0] frame;
    logic [5:0]       lsb;
    frame = {SYNC_BYTE, rec};
    lsb   = 6'(8 * (BYTES_PER_REC - 1 - int'(idx)));
    return frame[lsb +: 8];
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with full/empty flags.
//   clk, rst    : clock, asynchronous active-low reset
//   push, din   : write request and data (ignored when full unless popping)
//   pop, dout   : read request (ignored when empty) and head-of-queue data
//   full, empty : occupancy flags
// A simultaneous push and pop on a full FIFO is accepted: the pop frees the slot.
module trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int           AW      = $clog2(DEPTH);
  localparam logic [AW:0]  PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/acc_trace_tx.sv
// Trace transmitter: records every change of the CPU acc/mr outputs and
// sends each record as 8N1 UART bytes, LSB first.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   acc_in   : CPU accumulator value
//   mr_in    : CPU MR value
//   tx       : UART serial output, idle high (registered)
//   busy     : frame in flight or records queued (registered)
//   overflow : sticky, a record was dropped on a full FIFO (registered)
// Build option: TRACE_SYNC_EN prefixes every record with SYNC_BYTE.
module acc_trace_tx
  import acc_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] acc_in,
  input  logic [15:0] mr_in,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [2:0]    LAST_BYTE = 3'(BYTES_PER_REC - 1);

  state_t           state, state_next;
  logic [CW-1:0]    baud_cnt, baud_next;
  logic [2:0]       bit_idx, bit_next;
  logic [2:0]       byte_idx, byte_next;
  logic [REC_W-1:0] rec, rec_next;
  logic             tx_next, busy_next;

  logic [15:0]      last_acc, last_mr;
  logic             change, pop;
  logic [REC_W-1:0] fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [7:0]       cur_byte;
  logic             bit_end;

  // ---------------- change detector ----------------
  // last_* reset to 0, so a first nonzero input after reset is a change.
  assign change = (acc_in != last_acc) || (mr_in != last_mr);
  assign pop    = (state == IDLE) && !fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_acc <= '0;
      last_mr  <= '0;
      overflow <= 1'b0;
    end else begin
      last_acc <= acc_in;
      last_mr  <= mr_in;
      if (change && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (change),
    .din   ({mr_in, acc_in}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- UART framing FSM ----------------
  assign cur_byte = rec_byte(rec, byte_idx);
  assign bit_end  = (baud_cnt == BAUD_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    byte_next  = byte_idx;
    rec_next   = rec;
    tx_next    = 1'b1;
    busy_next  = (state != IDLE) || !fifo_empty;

    // tx follows the current state one cycle later, so the start bit of a
    // record popped at edge N+1 appears from edge N+2.
    case (state)
      IDLE:  tx_next = 1'b1;
      START: tx_next = 1'b0;
      DATA:  tx_next = cur_byte[bit_idx];
      STOP:  tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = START;
          rec_next   = fifo_dout;
          byte_next  = '0;
          baud_next  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = '0;
        end else begin
          baud_next = baud_cnt + BAUD_ONE;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 3'd1;
        end else begin
          baud_next = baud_cnt + BAUD_ONE;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_next = '0;
          if (byte_idx == LAST_BYTE) begin
            state_next = IDLE;
          end else begin
            state_next = START;
            byte_next  = byte_idx + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + BAUD_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      rec      <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      byte_idx <= byte_next;
      rec      <= rec_next;
      tx       <= tx_next;
      busy     <= busy_next;
    end
  end

endmodule

// File: tb/tb_acc_trace_tx.sv
// Directed testbench for acc_trace_tx: decodes the UART output and compares
// bytes, latency, busy, and overflow against hand-computed values.
// Honours TRACE_SYNC_EN the same way as the design.
module tb_acc_trace_tx;

  localparam int C     = 8;
  localparam int DEPTH = 4;
`ifdef TRACE_SYNC_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] acc_in = '0;
  logic [15:0] mr_in  = '0;
  logic        tx, busy, overflow;

  int tests = 0;
  int fails = 0;

  acc_trace_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .acc_in   (acc_in),
    .mr_in    (mr_in),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [15:0] mr, input logic [15:0] acc, input int idx);
`ifdef TRACE_SYNC_EN
    logic [39:0] s;
    s = {8'hA5, mr, acc};
    return s[39-8*idx -: 8];
`else
    logic [31:0] s;
    s = {mr, acc};
    return s[31-8*idx -: 8];
`endif
  endfunction

  // skew = cycles already elapsed inside the start bit at entry.
  task automatic recv_byte(input int skew, output logic [7:0] b);
    int n;
    n = 0;
    b = 'x;
    while (tx !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      check("start_timeout", {31'b0, tx}, 32'd0);
      return;
    end
    if (C/2 > skew) repeat (C/2 - skew) @(negedge clk);
    check("start_bit_mid", {31'b0, tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(negedge clk);
      b[i] = tx;
    end
    repeat (C) @(negedge clk);
    check("stop_bit_mid", {31'b0, tx}, 32'd1);
  endtask

  task automatic recv_record(input string tag, input logic [15:0] mr, input logic [15:0] acc, input int skew);
    logic [7:0] b;
    for (int k = 0; k < NB; k++) begin
      recv_byte((k == 0) ? skew : 0, b);
      check($sformatf("%s_byte%0d", tag, k), {24'b0, b}, {24'b0, exp_byte(mr, acc, k)});
    end
  endtask

  // Called from the middle of the final stop bit: busy holds through its last
  // cycle and drops on the following edge.
  task automatic end_of_record(input string tag);
    repeat (C/2 - 1) @(negedge clk);
    check({tag, "_busy_last_stop"}, {31'b0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
    check({tag, "_tx_idle"}, {31'b0, tx}, 32'd1);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int lows;
    lows = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check(tag, lows, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int n;

    // Reset held low with inputs at zero.
    #38;
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    #2 rst = 1'b1;
    quiet("idle_after_reset", 30);
    check("idle_busy", {31'b0, busy}, 32'd0);

    // Single change: push at N, pop at N+1, start bit from N+2.
    @(negedge clk) acc_in = 16'h1234;
    @(negedge clk);
    check("lat_n_tx", {31'b0, tx}, 32'd1);
    check("lat_n_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("lat_n1_tx", {31'b0, tx}, 32'd1);
    check("lat_n1_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("lat_n2_start", {31'b0, tx}, 32'd0);
    recv_record("single", 16'h0000, 16'h1234, 0);
    end_of_record("single");

    // Both registers change on one edge -> one record.
    @(negedge clk);
    acc_in = 16'h00FF;
    mr_in  = 16'hABCD;
    recv_record("simul", 16'hABCD, 16'h00FF, 0);
    end_of_record("simul");
    quiet("simul_single_record", 60);
    check("simul_ovf", {31'b0, overflow}, 32'd0);

    // Six changes on consecutive edges: 1 popped + 4 queued, 6th dropped.
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk) acc_in = 16'(i);
    end
    check("ovf_full_no_drop", {31'b0, overflow}, 32'd0);
    @(negedge clk);
    check("ovf_set", {31'b0, overflow}, 32'd1);
    recv_record("ovf_r1", 16'hABCD, 16'h0001, 3);
    for (int i = 2; i <= 5; i++) begin
      recv_record($sformatf("ovf_r%0d", i), 16'hABCD, 16'(i), 0);
    end
    end_of_record("ovf");
    check("ovf_sticky", {31'b0, overflow}, 32'd1);
    quiet("ovf_sixth_dropped", 60);
    check("ovf_sticky_late", {31'b0, overflow}, 32'd1);

    // Reset in the middle of DATA bit 3 of byte 1.
    @(negedge clk);
    acc_in = 16'h1111;
    mr_in  = 16'h2222;
    recv_byte(0, b);
    check("mid_byte0", {24'b0, b}, {24'b0, exp_byte(16'h2222, 16'h1111, 0)});
    n = 0;
    while (tx !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (4*C + C/2) @(negedge clk);
    check("mid_bit3_low", {31'b0, tx}, 32'd0);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_tx", {31'b0, tx}, 32'd1);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_ovf", {31'b0, overflow}, 32'd0);
    #40;
    @(negedge clk) rst = 1'b1;
    recv_record("after_rst", 16'h2222, 16'h1111, 0);
    end_of_record("after_rst");
    quiet("after_rst_quiet", 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
